// File: rtl/pc_next_pkg.sv
// Shared types and helpers for the next-PC unit: FSM state encoding, default reset PC,
// and width helpers used for the redirect-index and alignment logic.
package pc_next_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'd1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Index fields never collapse to zero bits, even with a single source.
    function automatic int idx_width(input int num_src);
        return (num_src > 32'sd1) ? clog2(num_src) : 32'sd1;
    endfunction

endpackage

// File: rtl/pc_prio_sel.sv
// Combinational fixed-priority redirect selector: the lowest-indexed valid source wins
// and its target address is forwarded.
module pc_prio_sel
    import pc_next_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0]          redir_valid,
    input  logic [NUM_SRC*WIDTH-1:0]    redir_pc,
    output logic                        any_valid,
    output logic [idx_width(NUM_SRC)-1:0] win_idx,
    output logic [WIDTH-1:0]            win_pc
);

    localparam int IDX_W = idx_width(NUM_SRC);

    // Scan from the lowest priority upwards so the last hit (lowest index) sticks.
    always_comb begin
        any_valid = 1'b0;
        win_idx   = {IDX_W{1'b0}};
        win_pc    = {WIDTH{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            any_valid = any_valid | redir_valid[i];
            win_idx   = redir_valid[i] ? IDX_W'(i) : win_idx;
            win_pc    = redir_valid[i] ? redir_pc[i*WIDTH +: WIDTH] : win_pc;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// PC register with prioritised redirects, stall hold and a one-entry pending-redirect buffer.
// Optional macro PC_ALIGN_CHECK_EN adds a one-cycle misalign flag for unaligned redirect targets.
module pc_next_unit
    import pc_next_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter int              NUM_SRC  = 3,
    parameter int              PC_INC   = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic [NUM_SRC-1:0]       redir_valid,
    input  logic [NUM_SRC*WIDTH-1:0] redir_pc,
    output logic [WIDTH-1:0]         pc_out,
    output logic                     pc_valid,
    output logic                     redirect_taken,
    output logic                     pending
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                     misalign
`endif
);

    localparam int               IDX_W      = idx_width(NUM_SRC);
    localparam logic [WIDTH-1:0] INC_VAL    = WIDTH'(PC_INC);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(PC_INC - 32'sd1);

    pc_state_e        state_r;
    pc_state_e        state_nxt_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic             pc_valid_r;
    logic             pc_valid_nxt_s;
    logic             taken_r;
    logic             taken_nxt_s;
    logic             pending_r;
    logic             pending_nxt_s;
    logic [WIDTH-1:0] pend_pc_r;
    logic [WIDTH-1:0] pend_pc_nxt_s;
    logic [IDX_W-1:0] pend_idx_r;
    logic [IDX_W-1:0] pend_idx_nxt_s;
    logic             load_redir_s;
    logic             take_new_s;

    logic             any_valid_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [WIDTH-1:0] win_pc_s;

    pc_prio_sel #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_prio_sel (
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .any_valid   (any_valid_s),
        .win_idx     (win_idx_s),
        .win_pc      (win_pc_s)
    );

    // A fresh winner replaces the buffered target only if it is at least as urgent.
    assign take_new_s = any_valid_s && (win_idx_s <= pend_idx_r);

    // Next-state and next-output decode for BOOT / RUN / PEND.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        pc_valid_nxt_s = pc_valid_r;
        taken_nxt_s    = 1'b0;
        pending_nxt_s  = pending_r;
        pend_pc_nxt_s  = pend_pc_r;
        pend_idx_nxt_s = pend_idx_r;
        load_redir_s   = 1'b0;
        case (state_r)
            BOOT: begin
                pc_valid_nxt_s = 1'b1;
                pending_nxt_s  = 1'b0;
                state_nxt_s    = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (any_valid_s) begin
                        pc_nxt_s     = win_pc_s;
                        taken_nxt_s  = 1'b1;
                        load_redir_s = 1'b1;
                    end else begin
                        pc_nxt_s = pc_r + INC_VAL;
                    end
                end else if (any_valid_s) begin
                    pend_pc_nxt_s  = win_pc_s;
                    pend_idx_nxt_s = win_idx_s;
                    pending_nxt_s  = 1'b1;
                    state_nxt_s    = PEND;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            PEND: begin
                if (stall) begin
                    if (take_new_s) begin
                        pend_pc_nxt_s  = win_pc_s;
                        pend_idx_nxt_s = win_idx_s;
                    end else begin
                        pend_pc_nxt_s = pend_pc_r;
                    end
                end else begin
                    pc_nxt_s      = take_new_s ? win_pc_s : pend_pc_r;
                    taken_nxt_s   = 1'b1;
                    load_redir_s  = 1'b1;
                    pending_nxt_s = 1'b0;
                    state_nxt_s   = RUN;
                end
            end
            default: begin
                state_nxt_s    = BOOT;
                pc_nxt_s       = RESET_PC;
                pc_valid_nxt_s = 1'b0;
                pending_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, PC and pending-buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= BOOT;
            pc_r       <= RESET_PC;
            pc_valid_r <= 1'b0;
            taken_r    <= 1'b0;
            pending_r  <= 1'b0;
            pend_pc_r  <= {WIDTH{1'b0}};
            pend_idx_r <= {IDX_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            pc_valid_r <= pc_valid_nxt_s;
            taken_r    <= taken_nxt_s;
            pending_r  <= pending_nxt_s;
            pend_pc_r  <= pend_pc_nxt_s;
            pend_idx_r <= pend_idx_nxt_s;
        end
    end

    assign pc_out         = pc_r;
    assign pc_valid       = pc_valid_r;
    assign redirect_taken = taken_r;
    assign pending        = pending_r;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_r;

    // Flag for one cycle whenever a redirect target with non-zero low bits is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= load_redir_s && ((pc_nxt_s & ALIGN_MASK) != {WIDTH{1'b0}});
        end
    end

    assign misalign = misalign_r;
`else
    logic unused_align_s;
    assign unused_align_s = load_redir_s & (|ALIGN_MASK);
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit: expectations are queued as each step is
// driven and popped/compared one cycle later, just after the clock edge.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [2:0]  redir_valid;
    logic [95:0] redir_pc;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        redirect_taken;
    logic        pending;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic        taken;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];

    pc_next_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .redirect_taken (redirect_taken),
        .pending        (pending)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then check them.
    task automatic step(input string tag, input logic rst, input logic stl, input logic [2:0] rv,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                        input logic [31:0] e_pc, input logic e_valid, input logic e_taken,
                        input logic e_pend, input logic e_mis);
        exp_t e;
        rst_n       = rst;
        stall       = stl;
        redir_valid = rv;
        redir_pc    = {p2, p1, p0};
        e.tag = tag; e.pc = e_pc; e.valid = e_valid; e.taken = e_taken; e.pend = e_pend; e.mis = e_mis;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compared++;
        assert (pc_out === e.pc) else begin
            mismatched++;
            $error("FAIL %s pc_out: got %h expected %h", e.tag, pc_out, e.pc);
        end
        compared++;
        assert (pc_valid === e.valid) else begin
            mismatched++;
            $error("FAIL %s pc_valid: got %b expected %b", e.tag, pc_valid, e.valid);
        end
        compared++;
        assert (redirect_taken === e.taken) else begin
            mismatched++;
            $error("FAIL %s redirect_taken: got %b expected %b", e.tag, redirect_taken, e.taken);
        end
        compared++;
        assert (pending === e.pend) else begin
            mismatched++;
            $error("FAIL %s pending: got %b expected %b", e.tag, pending, e.pend);
        end
`ifdef PC_ALIGN_CHECK_EN
        compared++;
        assert (misalign === e.mis) else begin
            mismatched++;
            $error("FAIL %s misalign: got %b expected %b", e.tag, misalign, e.mis);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redir_valid = 3'b000; redir_pc = 96'd0;
        #2;
        //    tag           rst  stl  rv      p0            p1            p2            exp_pc        v     tk    pnd   mis
        step("reset",       1'b0,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0000,1'b0,1'b0,1'b0,1'b0);
        step("boot_ign",    1'b1,1'b1,3'b001,32'h500,     32'h0,       32'h0,       32'h0000_0000,1'b1,1'b0,1'b0,1'b0);
        step("run_4",       1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0004,1'b1,1'b0,1'b0,1'b0);
        step("run_8",       1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0008,1'b1,1'b0,1'b0,1'b0);
        step("run_c",       1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_000C,1'b1,1'b0,1'b0,1'b0);
        step("simul_prio",  1'b1,1'b0,3'b110,32'h0,       32'h100,     32'h200,     32'h0000_0100,1'b1,1'b1,1'b0,1'b0);
        step("after_redir", 1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0104,1'b1,1'b0,1'b0,1'b0);
        step("stall_req",   1'b1,1'b1,3'b100,32'h0,       32'h0,       32'h200,     32'h0000_0104,1'b1,1'b0,1'b1,1'b0);
        step("stall_hold2", 1'b1,1'b1,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0104,1'b1,1'b0,1'b1,1'b0);
        step("stall_hold3", 1'b1,1'b1,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0104,1'b1,1'b0,1'b1,1'b0);
        step("stall_rel",   1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0200,1'b1,1'b1,1'b0,1'b0);
        step("post_rel",    1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0204,1'b1,1'b0,1'b0,1'b0);
        step("pend_src1",   1'b1,1'b1,3'b010,32'h0,       32'h100,     32'h0,       32'h0000_0204,1'b1,1'b0,1'b1,1'b0);
        step("pend_src0",   1'b1,1'b1,3'b001,32'h300,     32'h0,       32'h0,       32'h0000_0204,1'b1,1'b0,1'b1,1'b0);
        step("rel_src0",    1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0300,1'b1,1'b1,1'b0,1'b0);
        step("pend_keep0",  1'b1,1'b1,3'b001,32'h400,     32'h0,       32'h0,       32'h0000_0300,1'b1,1'b0,1'b1,1'b0);
        step("drop_src2",   1'b1,1'b1,3'b100,32'h0,       32'h0,       32'h600,     32'h0000_0300,1'b1,1'b0,1'b1,1'b0);
        step("rel_kept0",   1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0400,1'b1,1'b1,1'b0,1'b0);
        step("pend_700",    1'b1,1'b1,3'b001,32'h700,     32'h0,       32'h0,       32'h0000_0400,1'b1,1'b0,1'b1,1'b0);
        step("rel_low_new", 1'b1,1'b0,3'b100,32'h0,       32'h0,       32'h800,     32'h0000_0700,1'b1,1'b1,1'b0,1'b0);
        step("post_700",    1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0704,1'b1,1'b0,1'b0,1'b0);
        step("pend_900",    1'b1,1'b1,3'b100,32'h0,       32'h0,       32'h900,     32'h0000_0704,1'b1,1'b0,1'b1,1'b0);
        step("rel_hi_new",  1'b1,1'b0,3'b010,32'h0,       32'hA00,     32'h0,       32'h0000_0A00,1'b1,1'b1,1'b0,1'b0);
        step("stall_idle",  1'b1,1'b1,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0A00,1'b1,1'b0,1'b0,1'b0);
        step("redir_top",   1'b1,1'b0,3'b001,32'hFFFF_FFFC,32'h0,      32'h0,       32'hFFFF_FFFC,1'b1,1'b1,1'b0,1'b0);
        step("wrap_0",      1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0000,1'b1,1'b0,1'b0,1'b0);
        step("wrap_4",      1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0004,1'b1,1'b0,1'b0,1'b0);
        step("pend_beec",   1'b1,1'b1,3'b010,32'h0,       32'hBEEC,    32'h0,       32'h0000_0004,1'b1,1'b0,1'b1,1'b0);
        step("rst_in_pend", 1'b0,1'b1,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0000,1'b0,1'b0,1'b0,1'b0);
        step("reboot",      1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0000,1'b1,1'b0,1'b0,1'b0);
        step("no_stale_4",  1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0004,1'b1,1'b0,1'b0,1'b0);
        step("no_stale_8",  1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0008,1'b1,1'b0,1'b0,1'b0);
        step("unaligned",   1'b1,1'b0,3'b001,32'h102,     32'h0,       32'h0,       32'h0000_0102,1'b1,1'b1,1'b0,1'b1);
        step("mis_clear",   1'b1,1'b0,3'b000,32'h0,       32'h0,       32'h0,       32'h0000_0106,1'b1,1'b0,1'b0,1'b0);
        step("aligned",     1'b1,1'b0,3'b001,32'h104,     32'h0,       32'h0,       32'h0000_0104,1'b1,1'b1,1'b0,1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
